// File: rtl/ecc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ecc_pkg                                                   |
// | Purpose  : Shared extended-Hamming SECDED layout helpers used by     |
// |            both ecc_enc and ecc_dec so their layouts always match.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ecc_pkg;

  // Smallest m with 2^m >= m + k + 1 (number of Hamming check bits).
  // Scanning downwards leaves the smallest qualifying value in m.
  function automatic int calc_m(input int k);
    int m;
    m = 0;
    for (int j = 16; j >= 1; j--) begin
      if ((1 << j) >= j + k + 1) m = j;
    end
    return m;
  endfunction

  // True when p is a power of two, i.e. a check-bit position.
  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Hamming position p (1..n) -> code-word bit index.
  function automatic int pos2bit(input int p, input int p0_lsb);
    return (p0_lsb != 0) ? p : p - 1;
  endfunction

  // Code-word bit index holding the overall parity bit P0.
  function automatic int p0_bit(input int n, input int p0_lsb);
    return (p0_lsb != 0) ? 0 : n;
  endfunction

  // Information bit idx -> Hamming position: idx-th non-power-of-two
  // position counting upward from 3.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 512; p++) begin
      if (!is_pow2(p)) begin
        if ((cnt == idx) && (pos == 0)) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_dec_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ecc_dec_core                                              |
// | Purpose  : Combinational SECDED syndrome, parity check, single-bit   |
// |            correction and information-bit extraction.                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ecc_dec_core
  import ecc_pkg::*;
#(
  parameter int K      = 8,
  parameter int P0_LSB = 1,
  localparam int M     = calc_m(K),
  localparam int N     = M + K
) (
  input  logic [N:0]   i_d,
  output logic [K-1:0] o_q,
  output logic [M-1:0] o_syndrome,
  output logic         o_sb_err,
  output logic         o_db_err,
  output logic         o_sb_fix
);

  logic [M-1:0] w_terms [1:N];
  logic [M-1:0] w_syn;
  logic         w_pc;
  logic         w_in_range;
  logic         w_flip;

  // Each set Hamming position contributes its own index to the syndrome.
  for (genvar gp = 1; gp <= N; gp++) begin : g_syn_terms
    assign w_terms[gp] = i_d[pos2bit(gp, P0_LSB)] ? M'(gp) : '0;
  end

  // XOR-fold the per-position contributions into the syndrome.
  always_comb begin
    w_syn = '0;
    for (int p = 1; p <= N; p++) begin
      w_syn = w_syn ^ w_terms[p];
    end
  end

  assign w_pc       = ^i_d;
  assign w_in_range = (int'(w_syn) <= N);
  // Odd parity plus an in-range non-zero syndrome names the flipped bit.
  assign w_flip     = w_pc && (w_syn != '0) && w_in_range;

  // Only information bits matter at the output, so correction is applied
  // per extracted bit instead of rebuilding the whole code word.
  for (genvar gi = 0; gi < K; gi++) begin : g_extract
    localparam int c_pos = data_pos(gi);
    assign o_q[gi] = i_d[pos2bit(c_pos, P0_LSB)] ^
                     (w_flip && (int'(w_syn) == c_pos));
  end

  assign o_syndrome = w_syn;
  // syndrome 0 with odd parity is a flipped P0: still a single error.
  assign o_sb_err   = w_pc && w_in_range;
  assign o_db_err   = (w_syn != '0) && !(w_pc && w_in_range);
  assign o_sb_fix   = w_flip && !is_pow2(int'(w_syn));

endmodule
`default_nettype wire

// File: rtl/ecc_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ecc_dec                                                   |
// | Purpose  : Extended-Hamming SECDED decoder with 0, 1 or 2 cycles of  |
// |            optional pipelining around the combinational core.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module ecc_dec
  import ecc_pkg::*;
#(
  parameter int K       = 8,
  parameter int P0_LSB  = 1,
  parameter int LATENCY = 0,
  localparam int M      = calc_m(K),
  localparam int N      = M + K
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clkena_i,
  input  logic [N:0]   d_i,
  output logic [K-1:0] q_o,
  output logic [M-1:0] syndrome_o,
  output logic         sb_err_o,
  output logic         db_err_o,
  output logic         sb_fix_o
);

  logic [N:0]   w_core_d;
  logic [K-1:0] w_q;
  logic [M-1:0] w_syn;
  logic         w_sb;
  logic         w_db;
  logic         w_fix;

  if (LATENCY == 2) begin : g_in_reg
    logic [N:0] r_d;
    // Capture the incoming code word ahead of the decode logic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       r_d <= '0;
      else if (clkena_i) r_d <= d_i;
    end
    assign w_core_d = r_d;
  end else begin : g_in_comb
    assign w_core_d = d_i;
  end

  ecc_dec_core #(
    .K      (K),
    .P0_LSB (P0_LSB)
  ) u_core (
    .i_d        (w_core_d),
    .o_q        (w_q),
    .o_syndrome (w_syn),
    .o_sb_err   (w_sb),
    .o_db_err   (w_db),
    .o_sb_fix   (w_fix)
  );

  if (LATENCY == 0) begin : g_out_comb
    // Purely combinational: clock, reset and enable have no function here.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{clk_i, rst_ni, clkena_i};
    assign q_o        = w_q;
    assign syndrome_o = w_syn;
    assign sb_err_o   = w_sb;
    assign db_err_o   = w_db;
    assign sb_fix_o   = w_fix;
  end else begin : g_out_reg
    logic [K-1:0] r_q;
    logic [M-1:0] r_syn;
    logic         r_sb;
    logic         r_db;
    logic         r_fix;
    // Register decoded data and status flags together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_q   <= '0;
        r_syn <= '0;
        r_sb  <= 1'b0;
        r_db  <= 1'b0;
        r_fix <= 1'b0;
      end else if (clkena_i) begin
        r_q   <= w_q;
        r_syn <= w_syn;
        r_sb  <= w_sb;
        r_db  <= w_db;
        r_fix <= w_fix;
      end
    end
    assign q_o        = r_q;
    assign syndrome_o = r_syn;
    assign sb_err_o   = r_sb;
    assign db_err_o   = r_db;
    assign sb_fix_o   = r_fix;
  end

endmodule
`default_nettype wire

// File: tb/tb_ecc_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ecc_dec                                                |
// | Purpose  : Self-checking bench for ecc_dec (K=72 in both P0 layouts  |
// |            and all latencies, plus K=8 for out-of-range syndromes).  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_ecc_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clkena;
  logic [79:0] d_a, d_b, d_c;
  logic [12:0] d_e;

  logic [71:0] a_q, b_q, l1_q, l2_q;
  logic [6:0]  a_syn, b_syn, l1_syn, l2_syn;
  logic        a_sb, a_db, a_fix, b_sb, b_db, b_fix;
  logic        l1_sb, l1_db, l1_fix, l2_sb, l2_db, l2_fix;
  logic [7:0]  e_q;
  logic [3:0]  e_syn;
  logic        e_sb, e_db, e_fix;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ecc_dec #(.K(72), .P0_LSB(0), .LATENCY(0)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d_a), .q_o(a_q),
    .syndrome_o(a_syn), .sb_err_o(a_sb), .db_err_o(a_db), .sb_fix_o(a_fix));
  ecc_dec #(.K(72), .P0_LSB(1), .LATENCY(0)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d_b), .q_o(b_q),
    .syndrome_o(b_syn), .sb_err_o(b_sb), .db_err_o(b_db), .sb_fix_o(b_fix));
  ecc_dec #(.K(72), .P0_LSB(0), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d_c), .q_o(l1_q),
    .syndrome_o(l1_syn), .sb_err_o(l1_sb), .db_err_o(l1_db), .sb_fix_o(l1_fix));
  ecc_dec #(.K(72), .P0_LSB(0), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d_c), .q_o(l2_q),
    .syndrome_o(l2_syn), .sb_err_o(l2_sb), .db_err_o(l2_db), .sb_fix_o(l2_fix));
  ecc_dec #(.K(8), .P0_LSB(1), .LATENCY(0)) u_k8 (
    .clk_i(clk), .rst_ni(rst_n), .clkena_i(clkena), .d_i(d_e), .q_o(e_q),
    .syndrome_o(e_syn), .sb_err_o(e_sb), .db_err_o(e_db), .sb_fix_o(e_fix));

  // ---------------- reference model ----------------
  function automatic int tb_m(input int k);
    int m = 1;
    while ((1 << m) < m + k + 1) m++;
    return m;
  endfunction

  function automatic bit tb_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Hamming position (0 = P0) -> code-word bit index, and back.
  function automatic int idx_of(input int p, input int n, input bit lsb);
    if (p == 0) return lsb ? 0 : n;
    return lsb ? p : p - 1;
  endfunction

  function automatic int pos_of(input int b, input int n, input bit lsb);
    if (lsb) return b;
    return (b == n) ? 0 : b + 1;
  endfunction

  function automatic logic [79:0] enc(input logic [71:0] data, input int k, input bit lsb);
    int n, di, s;
    logic [127:0] hp;
    logic [79:0]  w;
    n = tb_m(k) + k; di = 0; s = 0; hp = '0; w = '0;
    for (int p = 1; p <= n; p++) begin
      if (!tb_pow2(p)) begin
        hp[p] = data[di];
        if (data[di]) s = s ^ p;
        di++;
      end
    end
    for (int j = 0; j < tb_m(k); j++) hp[1 << j] = s[j];
    hp[0] = ^hp;
    for (int p = 0; p <= n; p++) w[idx_of(p, n, lsb)] = hp[p];
    return w;
  endfunction

  function automatic logic [71:0] extract(input logic [79:0] w, input int k, input bit lsb);
    int n, di;
    logic [71:0] q;
    n = tb_m(k) + k; di = 0; q = '0;
    for (int p = 1; p <= n; p++) begin
      if (!tb_pow2(p)) begin
        q[di] = w[idx_of(p, n, lsb)];
        di++;
      end
    end
    return q;
  endfunction

  function automatic logic [71:0] rand72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  // Expected {syndrome, sb, db, fix} for one flipped bit b of an 80-bit word.
  function automatic logic [9:0] single_st(input int b, input bit lsb);
    int pos;
    pos = pos_of(b, 79, lsb);
    return {7'(pos), 1'b1, 1'b0, (pos != 0) && !tb_pow2(pos)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1; clkena = 1'b1;
    d_c = enc(rand72() | 72'h1, 72, 1'b0) ^ 80'h4;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({l1_q, l1_syn, l1_sb, l1_db, l1_fix} !== 82'h0)
      $display("FAIL reset_lat1: got %h expected 0", {l1_q, l1_syn, l1_sb, l1_db, l1_fix});
    else n_pass++;
    n_total++;
    if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== 82'h0)
      $display("FAIL reset_lat2: got %h expected 0", {l2_q, l2_syn, l2_sb, l2_db, l2_fix});
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [79:0] w1;
    logic [71:0] exp_q [5];
    logic [9:0]  exp_st[5];
    logic [79:0] words [5];
    w1 = enc(72'h1, 72, 1'b0);
    words[0] = 80'h0;                  exp_q[0] = 72'h0; exp_st[0] = {7'd0, 3'b000};
    words[1] = w1 ^ (80'h1 << 2);      exp_q[1] = 72'h1; exp_st[1] = {7'd3, 3'b101};
    words[2] = w1 ^ 80'h1;             exp_q[2] = 72'h1; exp_st[2] = {7'd1, 3'b100};
    words[3] = w1 ^ (80'h1 << 79);     exp_q[3] = 72'h1; exp_st[3] = {7'd0, 3'b100};
    words[4] = w1 ^ 80'h14;            exp_q[4] = 72'h2; exp_st[4] = {7'd6, 3'b010};
    for (int i = 0; i < 5; i++) begin
      d_a = words[i];
      #1;
      n_total++;
      if (a_q !== exp_q[i]) $display("FAIL directed_q[%0d]: got %h expected %h", i, a_q, exp_q[i]);
      else n_pass++;
      n_total++;
      if ({a_syn, a_sb, a_db, a_fix} !== exp_st[i])
        $display("FAIL directed_status[%0d]: got %h expected %h", i, {a_syn, a_sb, a_db, a_fix}, exp_st[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single_flips();
    logic [71:0] data;
    logic [79:0] mk;
    for (int b = 0; b < 80; b++) begin
      data = rand72();
      mk = 80'h1 << b;
      d_a = enc(data, 72, 1'b0) ^ mk;
      d_b = enc(data, 72, 1'b1) ^ mk;
      #1;
      n_total++;
      if ({a_q, a_syn, a_sb, a_db, a_fix} !== {data, single_st(b, 1'b0)})
        $display("FAIL single_msb bit %0d: got %h expected %h", b, {a_q, a_syn, a_sb, a_db, a_fix}, {data, single_st(b, 1'b0)});
      else n_pass++;
      n_total++;
      if ({b_q, b_syn, b_sb, b_db, b_fix} !== {data, single_st(b, 1'b1)})
        $display("FAIL single_lsb bit %0d: got %h expected %h", b, {b_q, b_syn, b_sb, b_db, b_fix}, {data, single_st(b, 1'b1)});
      else n_pass++;
    end
  endtask

  task automatic test_double_flips();
    logic [71:0] data;
    logic [79:0] wa, wb;
    logic [81:0] ea, eb;
    for (int x = 0; x < 80; x++) begin
      for (int y = x + 1; y < 80; y++) begin
        data = rand72();
        wa = enc(data, 72, 1'b0) ^ (80'h1 << x) ^ (80'h1 << y);
        wb = enc(data, 72, 1'b1) ^ (80'h1 << x) ^ (80'h1 << y);
        ea = {extract(wa, 72, 1'b0), 7'(pos_of(x, 79, 1'b0) ^ pos_of(y, 79, 1'b0)), 3'b010};
        eb = {extract(wb, 72, 1'b1), 7'(pos_of(x, 79, 1'b1) ^ pos_of(y, 79, 1'b1)), 3'b010};
        d_a = wa; d_b = wb;
        #1;
        n_total++;
        if ({a_q, a_syn, a_sb, a_db, a_fix} !== ea)
          $display("FAIL double_msb bits %0d,%0d: got %h expected %h", x, y, {a_q, a_syn, a_sb, a_db, a_fix}, ea);
        else n_pass++;
        n_total++;
        if ({b_q, b_syn, b_sb, b_db, b_fix} !== eb)
          $display("FAIL double_lsb bits %0d,%0d: got %h expected %h", x, y, {b_q, b_syn, b_sb, b_db, b_fix}, eb);
        else n_pass++;
      end
    end
  endtask

  // Stream, clock-enable and mid-stream reset share one expectation history.
  logic [81:0] hist [0:31];

  function automatic logic [79:0] make_word(input int c);
    logic [71:0] data;
    int b;
    data = rand72() | 72'h1;
    b = $urandom_range(79, 0);
    hist[c] = {data, single_st(b, 1'b0)};
    return enc(data, 72, 1'b0) ^ (80'h1 << b);
  endfunction

  task automatic test_latency();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk) d_c = make_word(c);
      @(posedge clk);
      #1;
      n_total++;
      if ({l1_q, l1_syn, l1_sb, l1_db, l1_fix} !== hist[c])
        $display("FAIL latency1 cycle %0d: got %h expected %h", c, {l1_q, l1_syn, l1_sb, l1_db, l1_fix}, hist[c]);
      else n_pass++;
      if (c >= 1) begin
        n_total++;
        if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== hist[c-1])
          $display("FAIL latency2 cycle %0d: got %h expected %h", c, {l2_q, l2_syn, l2_sb, l2_db, l2_fix}, hist[c-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clkena();
    @(negedge clk) begin clkena = 1'b0; d_c = make_word(20); end
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({l1_q, l1_syn, l1_sb, l1_db, l1_fix} !== hist[19])
      $display("FAIL clkena_hold_lat1: got %h expected %h", {l1_q, l1_syn, l1_sb, l1_db, l1_fix}, hist[19]);
    else n_pass++;
    n_total++;
    if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== hist[18])
      $display("FAIL clkena_hold_lat2: got %h expected %h", {l2_q, l2_syn, l2_sb, l2_db, l2_fix}, hist[18]);
    else n_pass++;
    @(negedge clk) clkena = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if ({l1_q, l1_syn, l1_sb, l1_db, l1_fix} !== hist[20])
      $display("FAIL clkena_resume_lat1: got %h expected %h", {l1_q, l1_syn, l1_sb, l1_db, l1_fix}, hist[20]);
    else n_pass++;
    n_total++;
    if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== hist[19])
      $display("FAIL clkena_resume_lat2: got %h expected %h", {l2_q, l2_syn, l2_sb, l2_db, l2_fix}, hist[19]);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk) d_c = make_word(21);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({l1_q, l1_syn, l1_sb, l1_db, l1_fix} !== 82'h0)
      $display("FAIL midreset_lat1: got %h expected 0", {l1_q, l1_syn, l1_sb, l1_db, l1_fix});
    else n_pass++;
    n_total++;
    if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== 82'h0)
      $display("FAIL midreset_lat2: got %h expected 0", {l2_q, l2_syn, l2_sb, l2_db, l2_fix});
    else n_pass++;
    @(negedge clk) begin rst_n = 1'b1; d_c = make_word(22); end
    @(posedge clk);
    #1;
    n_total++;
    if ({l1_q, l1_syn, l1_sb, l1_db, l1_fix} !== hist[22])
      $display("FAIL postreset_lat1: got %h expected %h", {l1_q, l1_syn, l1_sb, l1_db, l1_fix}, hist[22]);
    else n_pass++;
    n_total++;
    if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== 82'h0)
      $display("FAIL postreset_lat2_first: got %h expected 0", {l2_q, l2_syn, l2_sb, l2_db, l2_fix});
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({l2_q, l2_syn, l2_sb, l2_db, l2_fix} !== hist[22])
      $display("FAIL postreset_lat2: got %h expected %h", {l2_q, l2_syn, l2_sb, l2_db, l2_fix}, hist[22]);
    else n_pass++;
  endtask

  // K=8: n=12, so syndromes 13..15 are out of range for odd-parity patterns.
  task automatic test_k8_uncorrectable();
    logic [7:0]  data;
    logic [79:0] w;
    logic [12:0] masks [5];
    logic [14:0] exp   [5];
    data = 8'($urandom());
    w = enc({64'h0, data}, 8, 1'b1);
    masks[0] = 13'h000; exp[0] = {data,          4'd0,  3'b000};
    masks[1] = 13'h112; exp[1] = {data,          4'd13, 3'b010};
    masks[2] = 13'h114; exp[2] = {data,          4'd14, 3'b010};
    masks[3] = 13'h116; exp[3] = {data,          4'd15, 3'b010};
    masks[4] = 13'h120; exp[4] = {data ^ 8'h02,  4'd13, 3'b010};
    for (int i = 0; i < 5; i++) begin
      d_e = w[12:0] ^ masks[i];
      #1;
      n_total++;
      if ({e_q, e_syn, e_sb, e_db, e_fix} !== exp[i])
        $display("FAIL k8_case[%0d]: got %h expected %h", i, {e_q, e_syn, e_sb, e_db, e_fix}, exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b1; clkena = 1'b1;
    d_a = '0; d_b = '0; d_c = '0; d_e = '0;
    test_reset();
    test_directed();
    test_single_flips();
    test_double_flips();
    test_latency();
    test_clkena();
    test_reset_midstream();
    test_k8_uncorrectable();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
